node_mac_seq: RTL

Sequential, parametrised neuron node for the ECG inference layers. It replaces a fully unrolled multiplier/adder tree with one float_mult and one float_adder that are time-shared across N_INPUTS inputs.
- Weights and bias sit in a writable register file, so one instance serves any node.
- Activations stream in one per cycle on a valid/ready handshake.
- Result (bias + sum of w_i*a_i, then optional ReLU) leaves on a valid/ready output, so nodes chain layer-to-layer.

---
 rtl/node_pkg.sv | 109 ++++++++++
 rtl/node_mac_dp.sv | 49 ++++
 rtl/node_mac_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/node_pkg.sv
// Shared types, constants and float32 arithmetic for the sequential neuron node.
// Optional build macro NODE_MAC_RELU_EN (consumed by node_mac_seq) selects a ReLU output.
package node_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO     = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_HALF    = 32'h3F00_0000;
    localparam logic [FP_W-1:0] FP_NEG_ONE = 32'hBF80_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // float_mult: single-precision multiply, denormals flushed to zero, round to nearest even.
    function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        logic              s;
        logic [47:0]       prod;
        logic signed [10:0] e;
        logic [23:0]       m;
        logic              rnd;
        logic              stk;
        logic [24:0]       mr;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        if (prod[47]) begin
            m   = prod[47:24];
            rnd = prod[23];
            stk = |prod[22:0];
            e   = e + 11'sd1;
        end else begin
            m   = prod[46:23];
            rnd = prod[22];
            stk = |prod[21:0];
        end
        mr = {1'b0, m} + {24'd0, rnd & (stk | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 11'sd1;
        end
        if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 11'sd0) return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    // float_adder: single-precision add, denormals flushed to zero, round to nearest even.
    function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        logic [31:0]       x;
        logic [31:0]       y;
        logic [7:0]        d;
        logic [26:0]       mx;
        logic [26:0]       my;
        logic [27:0]       s;
        logic signed [9:0] e;
        logic [24:0]       mr;
        logic              stk;
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d   = x[30:23] - y[30:23];
        mx  = {1'b1, x[22:0], 3'b000};
        my  = {1'b1, y[22:0], 3'b000};
        stk = 1'b0;
        if (d > 8'd26) begin
            my = 27'd1;
        end else begin
            stk = |(my & ~(27'h7FF_FFFF << d));
            my  = (my >> d) | {26'd0, stk};
        end
        e = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 10'sd1;
            end
        end else begin
            s = {1'b0, mx} - {1'b0, my};
            if (s == 28'd0) return FP_ZERO;
            for (int i = 0; i < 27; i++) begin
                if (!s[26]) begin
                    s = s << 1;
                    e = e - 10'sd1;
                end
            end
        end
        mr = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
        if (e <= 10'sd0) return {x[31], 31'd0};
        return {x[31], e[7:0], mr[22:0]};
    endfunction

endpackage

// File: rtl/node_mac_dp.sv
// Two-stage multiply/accumulate datapath: one multiplier and one adder shared by every beat.
module node_mac_dp
    import node_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_beat,
    input  logic            i_first,
    input  logic [FP_W-1:0] i_act,
    input  logic [FP_W-1:0] i_weight,
    input  logic [FP_W-1:0] i_bias,
    output logic            o_p_valid,
    output logic [FP_W-1:0] o_acc
);

    logic [FP_W-1:0] w_prod;
    logic [FP_W-1:0] w_sum;
    logic [FP_W-1:0] r_prod;
    logic [FP_W-1:0] r_acc;
    logic            r_p_valid;

    assign w_prod    = fp_mul(i_act, i_weight);
    assign w_sum     = fp_add(r_acc, r_prod);
    assign o_p_valid = r_p_valid;
    assign o_acc     = r_acc;

    // Stage 1: capture the product of each accepted beat and flag it for accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod    <= FP_ZERO;
            r_p_valid <= 1'b0;
        end else begin
            r_p_valid <= i_beat;
            if (i_beat) r_prod <= w_prod;
        end
    end

    // Stage 2: seed with the bias on a vector's first beat, then fold products in arrival order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= FP_ZERO;
        end else if (i_first) begin
            r_acc <= i_bias;
        end else if (r_p_valid) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/node_mac_seq.sv
// Sequential neuron node: FSM, beat counter, weight/bias register file and handshakes.
// Build macro NODE_MAC_RELU_EN: when defined the result passes through ReLU, otherwise it is linear.
module node_mac_seq
    import node_pkg::*;
#(
    parameter int          N_INPUTS = 15,
    parameter logic [31:0] BIAS_RST = 32'h0000_0000,
    localparam int         IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_we,
    input  logic [IDX_W-1:0] w_addr,
    input  logic [31:0]      w_data,
    input  logic             b_we,
    input  logic [31:0]      b_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;
    logic [FP_W-1:0]  r_weights [N_INPUTS];
    logic [FP_W-1:0]  r_bias;
    logic             w_fire;
    logic             w_first;
    logic             w_last;
    logic             w_wr_open;
    logic             w_addr_ok;
    logic             w_p_valid;
    logic [FP_W-1:0]  w_acc;

    assign w_fire    = in_valid & in_ready;
    assign w_first   = w_fire & (r_state == IDLE);
    assign w_last    = (r_cnt == IDX_W'(N_INPUTS - 1));
    assign w_wr_open = (r_state == IDLE);
    assign w_addr_ok = ({1'b0, w_addr} < (IDX_W + 1)'(N_INPUTS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: collect N beats, let the last product land, then hold until downstream takes it.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_fire) w_next = w_last ? DRAIN : ACCUM;
            ACCUM:   if (w_fire && w_last) w_next = DRAIN;
            DRAIN:   if (!w_p_valid) w_next = OUT;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from state; in_ready is also held low while reset is asserted.
    always_comb begin
        in_ready  = rst_n & ((r_state == IDLE) | (r_state == ACCUM));
        out_valid = (r_state == OUT);
        busy      = (r_state != IDLE);
    end

    // Beat counter doubles as the weight index; it wraps to zero on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_fire) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Weight and bias writes land only between vectors so a running vector sees a stable set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) r_weights[i] <= FP_ZERO;
            r_bias <= BIAS_RST;
        end else if (w_wr_open) begin
            if (w_we && w_addr_ok) r_weights[w_addr] <= w_data;
            if (b_we) r_bias <= b_data;
        end
    end

    node_mac_dp u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_beat    (w_fire),
        .i_first   (w_first),
        .i_act     (in_data),
        .i_weight  (r_weights[r_cnt]),
        .i_bias    (r_bias),
        .o_p_valid (w_p_valid),
        .o_acc     (w_acc)
    );

`ifdef NODE_MAC_RELU_EN
    assign out_data = w_acc[31] ? FP_ZERO : w_acc;
`else
    assign out_data = w_acc;
`endif

endmodule
